// File: rtl/fec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fec_pkg
// Purpose  : Shared types and defaults for the 2-D parity FEC frame path.
// Revision : 1.0 - initial release
// ============================================================================
package fec_pkg;

  localparam int FEC_WIDTH = 4;
  localparam int FEC_DEPTH = 4;
  localparam int CNT_W     = 16;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    CHECK = 2'd1,
    DRAIN = 2'd2
  } fec_state_e;

  // Saturating increment for the statistics counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fec_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fec_frame_ctrl_if
// Purpose  : Row-stream, status and counter bundle of the FEC frame controller.
// Revision : 1.0 - initial release
// ============================================================================
interface fec_frame_ctrl_if import fec_pkg::*; #(
  parameter int WIDTH = FEC_WIDTH,
  parameter int DEPTH = FEC_DEPTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic [DEPTH-1:0] in_row_parity;
  logic [WIDTH-1:0] in_col_parity;
  logic             cfg_drop_uncorr;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  logic             st_valid;
  logic             st_err_det;
  logic             st_err_corr;
  logic             st_err_uncorr;
  logic             st_err_frame;

  logic [CNT_W-1:0] cnt_frames;
  logic [CNT_W-1:0] cnt_corr;
  logic [CNT_W-1:0] cnt_uncorr;

  modport master (
    output in_valid, in_data, in_last, in_row_parity, in_col_parity,
           cfg_drop_uncorr, out_ready,
    input  in_ready, out_valid, out_data, out_last,
           st_valid, st_err_det, st_err_corr, st_err_uncorr, st_err_frame,
           cnt_frames, cnt_corr, cnt_uncorr
  );

  modport slave (
    input  in_valid, in_data, in_last, in_row_parity, in_col_parity,
           cfg_drop_uncorr, out_ready,
    output in_ready, out_valid, out_data, out_last,
           st_valid, st_err_det, st_err_corr, st_err_uncorr, st_err_frame,
           cnt_frames, cnt_corr, cnt_uncorr
  );

endinterface
`default_nettype wire

// File: rtl/fec.sv
`default_nettype none
// ============================================================================
// Module   : fec
// Purpose  : Combinational 2-D even-parity checker; repairs a single data bit.
// Revision : 1.0 - initial release
// ============================================================================
module fec import fec_pkg::*; #(
  parameter int WIDTH = FEC_WIDTH,
  parameter int DEPTH = FEC_DEPTH
) (
  input  logic [DEPTH*WIDTH-1:0] data_i,
  input  logic [DEPTH-1:0]       row_parity_i,
  input  logic [WIDTH-1:0]       col_parity_i,
  output logic [DEPTH*WIDTH-1:0] data_o,
  output logic                   error_detected_o,
  output logic                   error_corrected_o
);

  logic [DEPTH-1:0]       row_syn;
  logic [WIDTH-1:0]       col_syn;
  logic [DEPTH*WIDTH-1:0] flip_mask;
  logic                   single_bit;

  for (genvar i = 0; i < DEPTH; i++) begin : g_row
    assign row_syn[i] = (^data_i[i*WIDTH +: WIDTH]) ^ row_parity_i[i];
  end

  always_comb begin
    col_syn = col_parity_i;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        col_syn[j] = col_syn[j] ^ data_i[i*WIDTH + j];
      end
    end
  end

  // Outer product of the syndromes pinpoints the bad bit when each is one-hot.
  for (genvar i = 0; i < DEPTH; i++) begin : g_mrow
    for (genvar j = 0; j < WIDTH; j++) begin : g_mcol
      assign flip_mask[i*WIDTH + j] = row_syn[i] & col_syn[j];
    end
  end

  assign single_bit        = $onehot(row_syn) && $onehot(col_syn);
  assign error_detected_o  = (|row_syn) | (|col_syn);
  assign error_corrected_o = single_bit;
  assign data_o            = single_bit ? (data_i ^ flip_mask) : data_i;

endmodule
`default_nettype wire

// File: rtl/fec_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fec_frame_ctrl
// Purpose  : Buffers a frame of rows, runs it through the fec core, drains it.
// Revision : 1.0 - initial release
// ============================================================================
module fec_frame_ctrl import fec_pkg::*; #(
  parameter int WIDTH = FEC_WIDTH,
  parameter int DEPTH = FEC_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  fec_frame_ctrl_if.slave bus
);

  localparam int            RW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(DEPTH - 1);

  fec_state_e       state_q, state_d;
  logic [RW-1:0]    r_q, r_d;
  logic [WIDTH-1:0] row_q [DEPTH];
  logic [DEPTH-1:0] rpar_q;
  logic [WIDTH-1:0] cpar_q;

  logic st_valid_q,  st_valid_d;
  logic st_det_q,    st_det_d;
  logic st_corr_q,   st_corr_d;
  logic st_uncorr_q, st_uncorr_d;
  logic st_frame_q,  st_frame_d;

  logic [CNT_W-1:0] cnt_frames_q, cnt_frames_d;
  logic [CNT_W-1:0] cnt_corr_q,   cnt_corr_d;
  logic [CNT_W-1:0] cnt_uncorr_q, cnt_uncorr_d;

  logic row_we, par_we, chk_en, frame_err;
  logic in_ready, out_valid;

  logic [DEPTH*WIDTH-1:0] mat_raw, mat_fix;
  logic                   fec_det, fec_corr, fec_uncorr;

  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign mat_raw[i*WIDTH +: WIDTH] = row_q[i];
  end

  fec #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fec (
    .data_i            (mat_raw),
    .row_parity_i      (rpar_q),
    .col_parity_i      (cpar_q),
    .data_o            (mat_fix),
    .error_detected_o  (fec_det),
    .error_corrected_o (fec_corr)
  );

  assign fec_uncorr = fec_det & ~fec_corr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    row_we    = 1'b0;
    par_we    = 1'b0;
    chk_en    = 1'b0;
    frame_err = 1'b0;
    case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          row_we = 1'b1;
          if (r_q == LAST_ROW) begin
            r_d = '0;
            if (bus.in_last) begin
              par_we  = 1'b1;
              state_d = CHECK;
            end else begin
              frame_err = 1'b1;
            end
          end else if (bus.in_last) begin
            r_d       = '0;
            frame_err = 1'b1;
          end else begin
            r_d = r_q + RW'(1);
          end
        end
      end
      CHECK: begin
        chk_en  = 1'b1;
        state_d = (fec_uncorr && bus.cfg_drop_uncorr) ? LOAD : DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          if (r_q == LAST_ROW) begin
            r_d     = '0;
            state_d = LOAD;
          end else begin
            r_d = r_q + RW'(1);
          end
        end
      end
      default: begin
        state_d = LOAD;
        r_d     = '0;
      end
    endcase
  end

  // The frame buffer is overwritten in place with the core's output during CHECK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        row_q[i] <= '0;
      end
      rpar_q <= '0;
      cpar_q <= '0;
    end else begin
      if (row_we) begin
        row_q[r_q] <= bus.in_data;
      end else if (chk_en) begin
        for (int i = 0; i < DEPTH; i++) begin
          row_q[i] <= mat_fix[i*WIDTH +: WIDTH];
        end
      end
      if (par_we) begin
        rpar_q <= bus.in_row_parity;
        cpar_q <= bus.in_col_parity;
      end
    end
  end

  always_comb begin
    st_valid_d   = chk_en | frame_err;
    st_det_d     = chk_en & fec_det;
    st_corr_d    = chk_en & fec_corr;
    st_uncorr_d  = chk_en & fec_uncorr;
    st_frame_d   = frame_err;
    cnt_frames_d = sat_inc(cnt_frames_q, chk_en);
    cnt_corr_d   = sat_inc(cnt_corr_q, chk_en & fec_corr);
    cnt_uncorr_d = sat_inc(cnt_uncorr_q, chk_en & fec_uncorr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_valid_q   <= 1'b0;
      st_det_q     <= 1'b0;
      st_corr_q    <= 1'b0;
      st_uncorr_q  <= 1'b0;
      st_frame_q   <= 1'b0;
      cnt_frames_q <= '0;
      cnt_corr_q   <= '0;
      cnt_uncorr_q <= '0;
    end else begin
      st_valid_q   <= st_valid_d;
      st_det_q     <= st_det_d;
      st_corr_q    <= st_corr_d;
      st_uncorr_q  <= st_uncorr_d;
      st_frame_q   <= st_frame_d;
      cnt_frames_q <= cnt_frames_d;
      cnt_corr_q   <= cnt_corr_d;
      cnt_uncorr_q <= cnt_uncorr_d;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid;
  assign bus.out_data      = (state_q == DRAIN) ? row_q[r_q] : '0;
  assign bus.out_last      = (state_q == DRAIN) && (r_q == LAST_ROW);
  assign bus.st_valid      = st_valid_q;
  assign bus.st_err_det    = st_det_q;
  assign bus.st_err_corr   = st_corr_q;
  assign bus.st_err_uncorr = st_uncorr_q;
  assign bus.st_err_frame  = st_frame_q;
  assign bus.cnt_frames    = cnt_frames_q;
  assign bus.cnt_corr      = cnt_corr_q;
  assign bus.cnt_uncorr    = cnt_uncorr_q;

endmodule
`default_nettype wire

// File: tb/tb_fec_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fec_frame_ctrl
// Purpose  : Directed self-checking bench for fec_frame_ctrl (4x4 frames).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fec_frame_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passed = 0;

  // Rows listed row0..row3, each row MSB first.
  localparam logic [15:0] CLEAN = 16'b0111_1111_1111_1110;
  localparam logic [15:0] FLIP1 = 16'b0111_1111_1101_1110;
  localparam logic [15:0] FLIP2 = 16'b0111_1111_1001_1110;
  localparam logic [3:0]  RP    = 4'b1001;
  localparam logic [3:0]  CP    = 4'b1001;

  fec_frame_ctrl_if #(.WIDTH(4), .DEPTH(4)) bus ();

  fec_frame_ctrl #(.WIDTH(4), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] rows, input int nb, input int last_at);
    for (int b = 0; b < nb; b++) begin
      bus.in_valid      = 1'b1;
      bus.in_data       = rows[15-4*b -: 4];
      bus.in_last       = (b == last_at);
      bus.in_row_parity = RP;
      bus.in_col_parity = CP;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic st_chk(input string tag, input logic det, input logic corr,
                        input logic unc, input logic frm);
    chk({tag, ".st_valid"}, bus.st_valid, 1);
    chk({tag, ".det"}, bus.st_err_det, det);
    chk({tag, ".corr"}, bus.st_err_corr, corr);
    chk({tag, ".uncorr"}, bus.st_err_uncorr, unc);
    chk({tag, ".frame"}, bus.st_err_frame, frm);
  endtask

  task automatic cnt_chk(input string tag, input int f, input int c, input int u);
    chk({tag, ".cnt_frames"}, bus.cnt_frames, f);
    chk({tag, ".cnt_corr"}, bus.cnt_corr, c);
    chk({tag, ".cnt_uncorr"}, bus.cnt_uncorr, u);
  endtask

  task automatic drain(input string tag, input logic [15:0] rows);
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("%s.out_valid%0d", tag, b), bus.out_valid, 1);
      chk($sformatf("%s.out_data%0d", tag, b), bus.out_data, rows[15-4*b -: 4]);
      chk($sformatf("%s.out_last%0d", tag, b), bus.out_last, (b == 3));
      chk($sformatf("%s.in_ready%0d", tag, b), bus.in_ready, 0);
      if (b > 0) chk($sformatf("%s.st_pulse%0d", tag, b), bus.st_valid, 0);
      tick();
    end
    chk({tag, ".idle_in_ready"}, bus.in_ready, 1);
    chk({tag, ".idle_out_valid"}, bus.out_valid, 0);
  endtask

  initial begin
    rst                 = 1'b1;
    bus.in_valid        = 1'b0;
    bus.in_data         = '0;
    bus.in_last         = 1'b0;
    bus.in_row_parity   = '0;
    bus.in_col_parity   = '0;
    bus.cfg_drop_uncorr = 1'b0;
    bus.out_ready       = 1'b1;
    tick();
    chk("rst.out_valid", bus.out_valid, 0);
    chk("rst.out_last", bus.out_last, 0);
    chk("rst.out_data", bus.out_data, 0);
    chk("rst.st_valid", bus.st_valid, 0);
    chk("rst.st_flags", {bus.st_err_det, bus.st_err_corr, bus.st_err_uncorr, bus.st_err_frame}, 0);
    cnt_chk("rst", 0, 0, 0);
    rst = 1'b0;
    tick();
    chk("rst.in_ready", bus.in_ready, 1);

    // Clean frame: CHECK at N+1, status and first row at N+2.
    send(CLEAN, 4, 3);
    chk("clean.n1_in_ready", bus.in_ready, 0);
    chk("clean.n1_st_valid", bus.st_valid, 0);
    chk("clean.n1_out_valid", bus.out_valid, 0);
    tick();
    st_chk("clean", 0, 0, 0, 0);
    cnt_chk("clean", 1, 0, 0);
    drain("clean", CLEAN);

    // Single flipped bit in row 2 is repaired.
    send(FLIP1, 4, 3);
    tick();
    st_chk("flip1", 1, 1, 0, 0);
    cnt_chk("flip1", 2, 1, 0);
    drain("flip1", CLEAN);

    // Double flip in one row, dropped.
    bus.cfg_drop_uncorr = 1'b1;
    send(FLIP2, 4, 3);
    tick();
    st_chk("drop", 1, 0, 1, 0);
    cnt_chk("drop", 3, 1, 1);
    chk("drop.out_valid", bus.out_valid, 0);
    chk("drop.in_ready", bus.in_ready, 1);
    tick();
    chk("drop.st_pulse", bus.st_valid, 0);
    chk("drop.out_valid2", bus.out_valid, 0);
    bus.cfg_drop_uncorr = 1'b0;

    // Same double flip, passed through raw.
    send(FLIP2, 4, 3);
    tick();
    st_chk("raw", 1, 0, 1, 0);
    cnt_chk("raw", 4, 1, 2);
    drain("raw", FLIP2);

    // in_last on beat 2: framing error, then a normal frame.
    send(CLEAN, 3, 2);
    st_chk("early", 0, 0, 0, 1);
    chk("early.out_valid", bus.out_valid, 0);
    chk("early.in_ready", bus.in_ready, 1);
    cnt_chk("early", 4, 1, 2);
    tick();
    chk("early.st_pulse", bus.st_valid, 0);
    send(CLEAN, 4, 3);
    tick();
    st_chk("after_early", 0, 0, 0, 0);
    cnt_chk("after_early", 5, 1, 2);
    drain("after_early", CLEAN);

    // Fourth beat without in_last is also a framing error.
    send(CLEAN, 4, -1);
    st_chk("nolast", 0, 0, 0, 1);
    chk("nolast.in_ready", bus.in_ready, 1);
    cnt_chk("nolast", 5, 1, 2);
    tick();

    // Back-pressure on the first output row for 5 cycles.
    send(CLEAN, 4, 3);
    bus.out_ready = 1'b0;
    tick();
    st_chk("stall", 0, 0, 0, 0);
    cnt_chk("stall", 6, 1, 2);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall.valid%0d", k), bus.out_valid, 1);
      chk($sformatf("stall.data%0d", k), bus.out_data, 4'b0111);
      chk($sformatf("stall.last%0d", k), bus.out_last, 0);
      chk($sformatf("stall.in_ready%0d", k), bus.in_ready, 0);
      tick();
    end
    bus.out_ready = 1'b1;
    drain("stall", CLEAN);

    // Asynchronous reset after 2 beats, away from any clock edge.
    send(CLEAN, 2, -1);
    rst = 1'b1;
    #2;
    chk("arst.out_valid", bus.out_valid, 0);
    chk("arst.out_last", bus.out_last, 0);
    chk("arst.out_data", bus.out_data, 0);
    chk("arst.st_valid", bus.st_valid, 0);
    cnt_chk("arst", 0, 0, 0);
    #1;
    rst = 1'b0;
    tick();
    chk("arst.in_ready", bus.in_ready, 1);
    chk("arst.st_pulse", bus.st_valid, 0);
    send(CLEAN, 4, 3);
    tick();
    st_chk("post_rst", 0, 0, 0, 0);
    cnt_chk("post_rst", 1, 0, 0);
    drain("post_rst", CLEAN);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
